// File: rtl/uart_cmd_responder_if.sv
// UART command responder: receiver/transmitter handshake bundle.
// slave = responder side, master = UART/bench side.
interface uart_cmd_responder_if;
  logic [7:0] rx_data;
  logic       rx_complete_flag;
  logic       rx_complete_del_flag;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_complete_flag;
  logic       tx_complete_del_flag;

  modport slave (
    input  rx_data,
    input  rx_complete_flag,
    input  tx_busy,
    input  tx_complete_flag,
    output rx_complete_del_flag,
    output tx_data,
    output tx_start,
    output tx_complete_del_flag
  );

  modport master (
    output rx_data,
    output rx_complete_flag,
    output tx_busy,
    output tx_complete_flag,
    input  rx_complete_del_flag,
    input  tx_data,
    input  tx_start,
    input  tx_complete_del_flag
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// UART command responder: 16x8 register file driven by W/R frames.
// Optional macro CHECKSUM_EN appends an XOR checksum byte to frames.
module uart_cmd_responder #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_cmd_responder_if.slave   bus,
  output logic [7:0]            reg0,
  output logic                  frame_err
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, GET_CSUM,
    EXEC, SEND, WAIT_DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_regs [16];
  logic [7:0]  r_cmd;
  logic [7:0]  r_addr;
  logic [7:0]  r_data;
  logic        r_nak;
  logic [23:0] r_cnt;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;
  logic        r_rx_del;
  logic        r_tx_del;
  logic        r_ferr;
`ifdef CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic   w_rx_ok;
  logic   w_get;
  logic   w_tmo;
  logic   w_bad_addr;
  state_t w_after;

  // A byte is taken only in a receiving state and once the
  // previous clear handshake has fully completed.
  assign w_rx_ok = (r_state inside {IDLE, GET_ADDR, GET_DATA, GET_CSUM})
                   && bus.rx_complete_flag && !r_rx_del;
  assign w_get   = r_state inside {GET_ADDR, GET_DATA, GET_CSUM};
  assign w_tmo   = w_get && (r_cnt == TIMEOUT_CYCLES - 24'd1);
  assign w_bad_addr = (r_addr[7:4] != 4'h0);
`ifdef CHECKSUM_EN
  assign w_after = GET_CSUM;
`else
  assign w_after = EXEC;
`endif

  assign bus.tx_data              = r_tx_data;
  assign bus.tx_start             = r_tx_start;
  assign bus.rx_complete_del_flag = r_rx_del;
  assign bus.tx_complete_del_flag = r_tx_del;
  assign reg0      = r_regs[0];
  assign frame_err = r_ferr;

  // Frame FSM with receive/transmit handshakes and inter-byte timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      for (int i = 0; i < 16; i++) r_regs[i] <= 8'h00;
      r_cmd      <= 8'h00;
      r_addr     <= 8'h00;
      r_data     <= 8'h00;
      r_nak      <= 1'b0;
      r_cnt      <= 24'd0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_rx_del   <= 1'b0;
      r_tx_del   <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef CHECKSUM_EN
      r_csum     <= 8'h00;
`endif
    end else begin
      r_ferr <= 1'b0;

      if (r_rx_del && !bus.rx_complete_flag) r_rx_del <= 1'b0;
      else if (w_rx_ok)                      r_rx_del <= 1'b1;

      if (w_rx_ok || !w_get) r_cnt <= 24'd0;
      else if (!w_tmo)       r_cnt <= r_cnt + 24'd1;

      unique case (r_state)
        IDLE: begin
          if (w_rx_ok) begin
            r_cmd <= bus.rx_data;
`ifdef CHECKSUM_EN
            r_csum <= bus.rx_data;
`endif
            if (bus.rx_data == CMD_W || bus.rx_data == CMD_R) begin
              r_nak   <= 1'b0;
              r_state <= GET_ADDR;
            end else begin
              r_nak   <= 1'b1;
              r_state <= EXEC;
            end
          end
        end
        GET_ADDR: begin
          if (w_rx_ok) begin
            r_addr <= bus.rx_data;
`ifdef CHECKSUM_EN
            r_csum <= r_csum ^ bus.rx_data;
`endif
            r_state <= (r_cmd == CMD_W) ? GET_DATA : w_after;
          end else if (w_tmo) begin
            r_ferr  <= 1'b1;
            r_state <= IDLE;
          end
        end
        GET_DATA: begin
          if (w_rx_ok) begin
            r_data <= bus.rx_data;
`ifdef CHECKSUM_EN
            r_csum <= r_csum ^ bus.rx_data;
`endif
            r_state <= w_after;
          end else if (w_tmo) begin
            r_ferr  <= 1'b1;
            r_state <= IDLE;
          end
        end
`ifdef CHECKSUM_EN
        GET_CSUM: begin
          if (w_rx_ok) begin
            if (bus.rx_data != r_csum) r_nak <= 1'b1;
            r_state <= EXEC;
          end else if (w_tmo) begin
            r_ferr  <= 1'b1;
            r_state <= IDLE;
          end
        end
`endif
        EXEC: begin
          if (r_nak || w_bad_addr) begin
            r_tx_data <= NAK;
            r_ferr    <= 1'b1;
          end else if (r_cmd == CMD_W) begin
            r_regs[r_addr[3:0]] <= r_data;
            r_tx_data <= ACK;
          end else begin
            r_tx_data <= r_regs[r_addr[3:0]];
          end
          r_tx_start <= 1'b1;
          r_state    <= SEND;
        end
        SEND: begin
          if (bus.tx_busy) begin
            r_tx_start <= 1'b0;
            r_state    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (r_tx_del && !bus.tx_complete_flag) begin
            r_tx_del <= 1'b0;
            r_state  <= IDLE;
          end else if (bus.tx_complete_flag) begin
            r_tx_del <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
